// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command scheduler and its FIFOs.
package alu_pkg;

  localparam int ALU_OPW  = 8;
  localparam int ALU_RESW = 16;
  localparam int ALU_FNW  = 3;

  // alucon function codes
  localparam logic [ALU_FNW-1:0] FN_ADD  = 3'd0;
  localparam logic [ALU_FNW-1:0] FN_SUB  = 3'd1;
  localparam logic [ALU_FNW-1:0] FN_MUL  = 3'd2;
  localparam logic [ALU_FNW-1:0] FN_XOR  = 3'd3;
  localparam logic [ALU_FNW-1:0] FN_AND  = 3'd4;
  localparam logic [ALU_FNW-1:0] FN_OR   = 3'd5;
  localparam logic [ALU_FNW-1:0] FN_XNOR = 3'd6;
  localparam logic [ALU_FNW-1:0] FN_NAND = 3'd7;

  typedef logic [ALU_FNW-1:0] alu_fn_t;

  // Command FIFO entry: function plus both operands
  typedef struct packed {
    alu_fn_t              fn;
    logic [ALU_OPW-1:0]   op1;
    logic [ALU_OPW-1:0]   op2;
  } alu_cmd_t;

  // Result FIFO entry: function tag plus alucon's raw 16-bit result
  typedef struct packed {
    alu_fn_t              fn;
    logic [ALU_RESW-1:0]  data;
  } alu_res_t;

  localparam int CMD_W = $bits(alu_cmd_t);
  localparam int RES_W = $bits(alu_res_t);

endpackage

// File: rtl/alu_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push when full and pop when
// empty are ignored. Storage is not reset, only the pointers are.
module alu_sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Full when the wrap bits differ and the index bits match
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // Next-state for storage and pointers
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = wdata;
      wptr_d                = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer and storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_cmd_sched.sv
// Issue stage in front of alucon: buffers commands, issues them against a
// result-slot credit, and collects tagged results into an output FIFO.
import alu_pkg::*;

module alu_cmd_sched #(
  parameter int CDEPTH = 4,
  parameter int RDEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ALU_OPW-1:0]  cmd_op1,
  input  logic [ALU_OPW-1:0]  cmd_op2,
  input  logic [ALU_FNW-1:0]  cmd_fn,
  output logic                alu_enable,
  output logic [ALU_OPW-1:0]  alu_op1,
  output logic [ALU_OPW-1:0]  alu_op2,
  output logic [ALU_FNW-1:0]  alu_fn,
  input  logic [ALU_RESW-1:0] alu_result,
  input  logic                alu_valid,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ALU_RESW-1:0] res_data,
  output logic [ALU_FNW-1:0]  res_fn,
  output logic                err
);

  // Handshakes (cmd_* and res_*): a transfer happens at a posedge where
  // valid and ready are both 1. The source holds its payload stable while
  // valid is high and not yet accepted; ready never depends on valid, and
  // cmd_ready is derived only from registered state.

  localparam int UW = $clog2(RDEPTH) + 1;

  // FIFO interface
  alu_cmd_t cmd_wdata, cmd_head;
  alu_res_t res_wdata, res_head;
  logic     cmd_full, cmd_empty;
  logic     res_full, res_empty;
  logic     cmd_push, res_pop;

  // Issue / capture control
  logic     issue;
  logic     capture;
  logic     stray;

  // Registered state
  logic            live_q, live_d;
  logic [UW-1:0]   used_q, used_d;
  alu_fn_t         tag_q [2];
  alu_fn_t         tag_d [2];
  logic [1:0]      tag_cnt_q, tag_cnt_d;
  logic            alu_enable_q, alu_enable_d;
  logic [ALU_OPW-1:0] alu_op1_q, alu_op1_d;
  logic [ALU_OPW-1:0] alu_op2_q, alu_op2_d;
  alu_fn_t         alu_fn_q, alu_fn_d;
  logic            err_q, err_d;

  assign cmd_wdata = '{fn: cmd_fn, op1: cmd_op1, op2: cmd_op2};
  assign cmd_ready = live_q && !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;

  // A command may only leave the FIFO when a result slot is reserved for it
  assign issue   = !cmd_empty && (used_q < UW'(RDEPTH));
  assign capture = alu_valid && (tag_cnt_q != 2'd0);
  assign stray   = alu_valid && (tag_cnt_q == 2'd0);

  assign res_wdata = '{fn: tag_q[0], data: alu_result};
  assign res_valid = !res_empty;
  assign res_pop   = res_valid && res_ready;
  // Head is forced to zero while empty so the outputs are defined after reset
  assign res_data  = res_empty ? '0 : res_head.data;
  assign res_fn    = res_empty ? '0 : res_head.fn;

  assign alu_enable = alu_enable_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign alu_fn     = alu_fn_q;
  assign err        = err_q;

  alu_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CDEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .wdata (cmd_wdata),
    .pop   (issue),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  // The credit counter keeps this FIFO from ever being pushed while full
  alu_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RDEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .wdata (res_wdata),
    .pop   (res_pop),
    .rdata (res_head),
    .full  (res_full),
    .empty (res_empty)
  );

  // Credit counter: reserved = issued but not yet popped downstream
  always_comb begin
    used_d = used_q;
    case ({issue, res_pop})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: used_d = used_q;
    endcase
  end

  // In-flight tag queue: at most two tags (one issued this edge, one whose
  // result alucon is presenting), so a two-entry shift queue is enough
  always_comb begin
    tag_d     = tag_q;
    tag_cnt_d = tag_cnt_q;
    if (capture) begin
      tag_d[0]  = tag_q[1];
      tag_cnt_d = tag_cnt_d - 2'd1;
    end
    if (issue) begin
      tag_d[tag_cnt_d[0]] = cmd_head.fn;
      tag_cnt_d           = tag_cnt_d + 2'd1;
    end
  end

  // alucon drive: enable pulses on issue, operands hold between issues
  always_comb begin
    alu_enable_d = issue;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    alu_fn_d     = alu_fn_q;
    if (issue) begin
      alu_op1_d = cmd_head.op1;
      alu_op2_d = cmd_head.op2;
      alu_fn_d  = cmd_head.fn;
    end
  end

  // Sticky error for a result that no issued command is waiting for;
  // live goes high the first cycle out of reset to open cmd_ready
  always_comb begin
    err_d  = err_q | stray;
    live_d = 1'b1;
  end

  // All scheduler registers
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q       <= 1'b0;
      used_q       <= '0;
      tag_q[0]     <= FN_ADD;
      tag_q[1]     <= FN_ADD;
      tag_cnt_q    <= 2'd0;
      alu_enable_q <= 1'b0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_fn_q     <= FN_ADD;
      err_q        <= 1'b0;
    end else begin
      live_q       <= live_d;
      used_q       <= used_d;
      tag_q        <= tag_d;
      tag_cnt_q    <= tag_cnt_d;
      alu_enable_q <= alu_enable_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_fn_q     <= alu_fn_d;
      err_q        <= err_d;
    end
  end

  // res_full is implied by the credit scheme; it is kept only for debug visibility
  logic unused_res_full;
  assign unused_res_full = res_full;

endmodule
